mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one synchronous single-port memory.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/req1               access requests (port 0 = CPU, port 1 = DMA/IO)
//   we0/we1, addr0/addr1,
//   wdata0/wdata1           per-port command, held stable while reqx is high
//   ack0/ack1               one-cycle completion pulse per port
//   rdata0/rdata1           per-port read data, held until the next ack to that port
//   m_cs, m_we, m_addr,
//   m_wdata                 registered memory command
//   m_rdata                 memory read data (memory updates it on the negedge)
//   busy                    high while a transaction is in flight
//   gnt                     one-hot owner of the current transaction
module mem_arbiter #(
    parameter int RR         = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [6:0]  addr0,
    input  logic [6:0]  addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        m_cs,
    output logic        m_we,
    output logic [6:0]  m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic [1:0]  gnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] SMAX = 3'(STARVE_MAX);

    state_t     state, state_d;
    logic       load, done, pick1, last_gnt;
    logic [2:0] starve_cnt;

    // Port 1 wins when alone, or on a tie when it was not served last (round-robin)
    // or when port 0 has starved it for SMAX consecutive grants (fixed priority).
    assign pick1 = req1 && (!req0 || ((RR != 0) ? !last_gnt : (starve_cnt == SMAX)));
    assign busy  = state != IDLE;

    always_comb begin
        state_d = state;
        load    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                load    = req0 || req1;
                state_d = (req0 || req1) ? ACCESS : IDLE;
            end
            ACCESS: begin
                done    = 1'b1;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            m_cs       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            gnt        <= 2'b00;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            last_gnt   <= 1'b1;
            starve_cnt <= '0;
        end else begin
            state <= state_d;
            ack0  <= done && gnt[0];
            ack1  <= done && gnt[1];
            if (load) begin
                m_cs     <= 1'b1;
                m_we     <= pick1 ? we1 : we0;
                m_addr   <= pick1 ? addr1 : addr0;
                m_wdata  <= pick1 ? wdata1 : wdata0;
                gnt      <= pick1 ? 2'b10 : 2'b01;
                last_gnt <= pick1;
            end
            if (done) begin
                m_cs <= 1'b0;
                m_we <= 1'b0;
                if (!m_we && gnt[0]) rdata0 <= m_rdata;
                if (!m_we && gnt[1]) rdata1 <= m_rdata;
            end
            if (state == RESP) gnt <= 2'b00;
            // In IDLE with req1 high a grant always happens, so a non-pick1 cycle is a port-0 grant.
            if (state == IDLE)
                starve_cnt <= (!req1 || pick1) ? 3'd0 :
                              (starve_cnt != SMAX) ? starve_cnt + 3'd1 : starve_cnt;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives a round-robin and a fixed-priority arbiter with the same
// requests and checks both against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int SMAX = 4;

    logic        clk, rst_n, req0, req1, we0, we1;
    logic [6:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;

    logic        ack0_o [2], ack1_o [2], m_cs_o [2], m_we_o [2], busy_o [2];
    logic [31:0] rdata0_o [2], rdata1_o [2], m_wdata_o [2], m_rdata_i [2];
    logic [6:0]  m_addr_o [2];
    logic [1:0]  gnt_o [2];

    logic [31:0] mem [2][128];
    logic [31:0] ref_mem [2][128];

    int          start [2], cons [2];
    logic        last [2], win [2], wr [2];
    logic [6:0]  ad [2];
    logic [31:0] wd [2], er0 [2], er1 [2];
    int          cyc, n_cmp, n_err;
    int          qa [$], qb [$];

    mem_arbiter #(.RR(1), .STARVE_MAX(SMAX)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_o[0]), .ack1(ack1_o[0]), .rdata0(rdata0_o[0]), .rdata1(rdata1_o[0]),
        .m_cs(m_cs_o[0]), .m_we(m_we_o[0]), .m_addr(m_addr_o[0]), .m_wdata(m_wdata_o[0]),
        .m_rdata(m_rdata_i[0]), .busy(busy_o[0]), .gnt(gnt_o[0])
    );

    mem_arbiter #(.RR(0), .STARVE_MAX(SMAX)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_o[1]), .ack1(ack1_o[1]), .rdata0(rdata0_o[1]), .rdata1(rdata1_o[1]),
        .m_cs(m_cs_o[1]), .m_we(m_we_o[1]), .m_addr(m_addr_o[1]), .m_wdata(m_wdata_o[1]),
        .m_rdata(m_rdata_i[1]), .busy(busy_o[1]), .gnt(gnt_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        return (a == 127) ? 32'h0000_0001 : (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural memory: commands sampled on the negedge of the access cycle.
    initial begin
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 128; a++) mem[i][a] = init_val(a);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (m_cs_o[i]) begin
                    if (m_we_o[i]) mem[i][m_addr_o[i]] = m_wdata_o[i];
                    else m_rdata_i[i] = mem[i][m_addr_o[i]];
                end
        end
    end

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            start[i] = -1000; cons[i] = 0; last[i] = 1'b1; win[i] = 1'b0; wr[i] = 1'b0;
            ad[i] = '0; wd[i] = '0; er0[i] = '0; er1[i] = '0;
        end
    endtask

    // A transaction granted at cycle k occupies k (access), k+1 (ack) and k+2 (idle);
    // the next grant can happen at k+3. Instance 0 is round-robin, instance 1 fixed priority.
    task automatic model_step();
        logic w;
        for (int i = 0; i < 2; i++) begin
            if (rst_n) begin
                if (cyc - start[i] >= 3) begin
                    if (!req1) cons[i] = 0;
                    if (req0 || req1) begin
                        w = (req0 && req1) ? ((i == 0) ? !last[i] : (cons[i] >= SMAX)) : req1;
                        if (w) cons[i] = 0;
                        else if (req1 && cons[i] < SMAX) cons[i]++;
                        last[i] = w; start[i] = cyc; win[i] = w;
                        wr[i] = w ? we1 : we0;
                        ad[i] = w ? addr1 : addr0;
                        wd[i] = w ? wdata1 : wdata0;
                    end
                end
                if (cyc - start[i] == 1) begin
                    if (wr[i]) ref_mem[i][ad[i]] = wd[i];
                    else if (win[i]) er1[i] = ref_mem[i][ad[i]];
                    else er0[i] = ref_mem[i][ad[i]];
                end
            end
        end
    endtask

    task automatic check_all();
        int d;
        for (int i = 0; i < 2; i++) begin
            d = cyc - start[i];
            chk("m_cs", i, 32'(m_cs_o[i]), 32'(d == 0));
            chk("m_we", i, 32'(m_we_o[i]), 32'(d == 0 && wr[i]));
            chk("gnt", i, 32'(gnt_o[i]), (d <= 1) ? (win[i] ? 32'd2 : 32'd1) : 32'd0);
            chk("busy", i, 32'(busy_o[i]), 32'(d <= 1));
            chk("ack0", i, 32'(ack0_o[i]), 32'(d == 1 && !win[i]));
            chk("ack1", i, 32'(ack1_o[i]), 32'(d == 1 && win[i]));
            chk("m_addr", i, 32'(m_addr_o[i]), 32'(ad[i]));
            chk("m_wdata", i, m_wdata_o[i], wd[i]);
            chk("rdata0", i, rdata0_o[i], er0[i]);
            chk("rdata1", i, rdata1_o[i], er1[i]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            check_all();
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 128; a++) ref_mem[i][a] = init_val(a);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all();
        step(2);
        rst_n = 1'b1;

        // Port-0 write then read of the same word.
        req0 = 1; we0 = 1; addr0 = 7'h05; wdata0 = 32'hDEAD_BEEF;
        step(2);
        req0 = 0;
        step(1);
        req0 = 1; we0 = 0;
        step(2);
        req0 = 0;
        for (int i = 0; i < 2; i++) chk("rd_deadbeef", i, rdata0_o[i], 32'hDEAD_BEEF);
        step(1);

        // Port-1 read of the top address while port 0 is idle.
        req1 = 1; we1 = 0; addr1 = 7'h7F;
        step(2);
        req1 = 0;
        for (int i = 0; i < 2; i++) chk("rd_7f", i, rdata1_o[i], 32'h0000_0001);
        step(1);

        // Both ports held: record the owner of each transaction.
        req0 = 1; we0 = 0; addr0 = 7'h05;
        req1 = 1; we1 = 1; addr1 = 7'h10; wdata1 = 32'h1234_5678;
        for (int n = 0; n < 30; n++) begin
            step(1);
            if (m_cs_o[0]) qa.push_back(int'(gnt_o[0][1]));
            if (m_cs_o[1]) qb.push_back(int'(gnt_o[1][1]));
        end
        chk("n_grants", 0, 32'(qa.size()), 32'd10);
        chk("n_grants", 1, 32'(qb.size()), 32'd10);
        for (int j = 0; j < 10; j++) begin
            chk("seq_rr", j, 32'((j < qa.size()) ? qa[j] : 99), 32'(j % 2));
            chk("seq_fp", j, 32'((j < qb.size()) ? qb[j] : 99), 32'(j % 5 == 4));
        end
        req0 = 0; req1 = 0;
        step(3);

        // Port 1 requests only while port 0 is being served, then withdraws.
        req0 = 1; we0 = 1; addr0 = 7'h11; wdata0 = 32'hA5A5_0011;
        step(1);
        req1 = 1; we1 = 0; addr1 = 7'h12;
        step(1);
        req0 = 0; req1 = 0;
        step(3);

        // Reset in the access cycle of a write: abandoned, memory untouched.
        req0 = 1; we0 = 1; addr0 = 7'h22; wdata0 = 32'hCAFE_F00D;
        step(1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        req0 = 0;
        step(2);
        rst_n = 1'b1;
        req0 = 1; we0 = 0; addr0 = 7'h22;
        step(2);
        req0 = 0;
        for (int i = 0; i < 2; i++) chk("rd_after_rst", i, rdata0_o[i], init_val(34));
        step(1);

        // Randomized traffic.
        for (int n = 0; n < 450; n++) begin
            if (req0) req0 = $urandom_range(0, 5) != 0;
            else if ($urandom_range(0, 2) == 0) begin
                req0 = 1; we0 = 1'($urandom_range(0, 1));
                addr0 = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
                wdata0 = $urandom;
            end
            if (req1) req1 = $urandom_range(0, 5) != 0;
            else if ($urandom_range(0, 2) == 0) begin
                req1 = 1; we1 = 1'($urandom_range(0, 1));
                addr1 = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 15));
                wdata1 = $urandom;
            end
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
